// File: rtl/seq_div_12by6_if.sv
// Handshake and operand/result bundle for the sequential 12-by-6 divider.
// The master issues start with operands; the slave (divider) returns registered results.
interface seq_div_12by6_if #(
    parameter int DW_DVD = 12,
    parameter int DW_DVS = 6
);
    logic              start;
    logic [DW_DVD-1:0] dividend;
    logic [DW_DVS-1:0] divisor;
    logic              ready;
    logic              done;
    logic [DW_DVD-1:0] quotient;
    logic [DW_DVS-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_12by6.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// The dividend register doubles as the quotient shift register during CALC.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready=1, waiting for start; operands captured on accept
//   CALC  | one restoring step per edge, DW_DVD steps in total
//   DONE  | done=1 for one cycle, results already registered
module seq_div_12by6 #(
    parameter int DW_DVD = 12,
    parameter int DW_DVS = 6,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_div_12by6_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DW_DVD-1:0] dvd_q, dvd_d;
    logic [DW_DVS-1:0] dvs_q, dvs_d;
    logic [DW_DVS:0]   rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW_DVD-1:0] quot_q, quot_d;
    logic [DW_DVS-1:0] remo_q, remo_d;
    logic              dbz_q, dbz_d;

    // One bit wider than the partial remainder so the compare sees every stored bit.
    logic [DW_DVS+1:0] trial;
    logic [DW_DVS:0]   diff;
    logic              ge;

    always_comb begin
        trial = {rem_q, dvd_q[DW_DVD-1]};
        ge    = (trial >= {2'b00, dvs_q});
        diff  = trial[DW_DVS:0] - {1'b0, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvd_d = bus.dividend;
                    dvs_d = bus.divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        remo_d  = '0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                rem_d = ge ? diff : trial[DW_DVS:0];
                dvd_d = {dvd_q[DW_DVD-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                // Last step: publish the finished quotient/remainder in the same edge.
                if (cnt_q == CW'(DW_DVD - 1)) begin
                    quot_d  = dvd_d;
                    remo_d  = rem_d[DW_DVS-1:0];
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.ready       = (state_q == S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;

endmodule
